// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default width for the PWM generator
// Contents: state_t (ST_IDLE, ST_HIGH, ST_LOW, 2 bits), W_DEF (default count width)
package pwm_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;
   localparam int W_DEF = 32;
endpackage

// File: rtl/pwm_cfg_buf.sv
// pwm_cfg_buf: pending/active configuration double buffer with valid/ready intake
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_valid/o_ready config offer / pending slot free (o_ready = !pending valid)
//   i_cfg           packed config word captured on handshake
//   i_load          period-boundary strobe; copies pending to active if pending is valid
//   o_pend_v        pending slot holds an unapplied config
//   o_act           currently active config
//   o_nxt           config that will be active after a boundary (pending if valid, else active)
module pwm_cfg_buf
   import pwm_pkg::*;
#(
   parameter int CW = 2 * W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [CW-1:0] i_cfg,
   input  logic          i_load,
   output logic          o_pend_v,
   output logic [CW-1:0] o_act,
   output logic [CW-1:0] o_nxt
);
   logic          r_pend_v;
   logic [CW-1:0] r_pend, r_act;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_v <= 1'b0;
         r_pend   <= '0;
         r_act    <= '0;
      end else begin
         if (i_load && r_pend_v) begin
            r_act    <= r_pend;
            r_pend_v <= 1'b0;
         end
         // a handshake can only occur while the slot is empty, so it never
         // collides with a transfer; one landing on a boundary waits a period
         if (i_valid && o_ready) begin
            r_pend   <= i_cfg;
            r_pend_v <= 1'b1;
         end
      end
   end
   assign o_ready  = !r_pend_v;
   assign o_pend_v = r_pend_v;
   assign o_act    = r_act;
   assign o_nxt    = r_pend_v ? r_pend : r_act;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: programmable PWM generator with boundary-synchronous config updates
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   en                    level-sensitive run request
//   cfg_valid/cfg_ready   config handshake for cfg_high/cfg_period
//   cfg_high, cfg_period  high time and period in clk cycles
//   sig                   registered waveform
//   period_start          pulse in the first cycle of each period
//   busy                  generator not idle
// Option PWM_BURST_EN: adds cfg_burst (periods per burst, 0 = continuous) and done pulse
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_high,
   input  logic [W-1:0] cfg_period,
`ifdef PWM_BURST_EN
   input  logic [15:0]  cfg_burst,
   output logic         done,
`endif
   output logic         sig,
   output logic         period_start,
   output logic         busy
);
`ifdef PWM_BURST_EN
   localparam int CW = 2 * W + 16;
`else
   localparam int CW = 2 * W;
`endif
   state_t        r_state, w_state;
   logic [W-1:0]  r_cnt, w_cnt;
   logic [W-1:0]  w_act_high, w_act_period, w_nxt_high, w_nxt_period;
   logic          r_sig, w_sig, r_ps, w_ps;
   logic          w_pend_v, w_bnd, w_last, w_idle_ok, w_cont;
   logic [CW-1:0] w_cfg, w_act, w_nxt;
`ifdef PWM_BURST_EN
   assign w_cfg = {cfg_burst, cfg_high, cfg_period};
`else
   assign w_cfg = {cfg_high, cfg_period};
`endif
   pwm_cfg_buf #(.CW(CW)) u_cfg (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (cfg_valid),
      .o_ready  (cfg_ready),
      .i_cfg    (w_cfg),
      .i_load   (w_bnd),
      .o_pend_v (w_pend_v),
      .o_act    (w_act),
      .o_nxt    (w_nxt)
   );
   assign w_act_period = w_act[W-1:0];
   assign w_act_high   = w_act[2*W-1:W];
   assign w_nxt_period = w_nxt[W-1:0];
   assign w_nxt_high   = w_nxt[2*W-1:W];
   // only meaningful while running, when the active period is nonzero
   assign w_last = r_cnt == w_act_period - W'(1);
   // a boundary loads pending config and, if the resulting period is nonzero, starts a period
   assign w_bnd = r_state == ST_IDLE ? en && w_idle_ok && (w_pend_v || w_act_period != '0)
                                     : en && w_last && w_cont;
`ifdef PWM_BURST_EN
   logic [15:0] r_pn, w_pn, w_act_burst;
   logic        r_lock, w_lock, r_done, w_done;
   assign w_act_burst = w_act[CW-1:2*W];
   // after a finished burst, en must be seen low before another start
   assign w_idle_ok = !r_lock;
   // a pending load restarts the count, so it always continues
   assign w_cont = w_pend_v || w_act_burst == '0 || r_pn != w_act_burst;
   assign w_done = r_state != ST_IDLE && en && w_last && !w_cont;
   assign w_lock = w_done || (r_lock && en);
   assign w_pn   = !w_bnd ? r_pn : (w_pend_v || r_state == ST_IDLE) ? 16'd1 : r_pn + 16'd1;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pn   <= '0;
         r_lock <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_pn   <= w_pn;
         r_lock <= w_lock;
         r_done <= w_done;
      end
   end
   assign done = r_done;
`else
   assign w_idle_ok = 1'b1;
   assign w_cont    = 1'b1;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sig   <= 1'b0;
         r_ps    <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_sig   <= w_sig;
         r_ps    <= w_ps;
      end
   end
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt + W'(1);
      w_sig   = r_sig;
      w_ps    = 1'b0;
      // end of period checked before end of high time so high>=period gives 100% duty
      if (r_state == ST_IDLE || w_last) begin
         w_state = ST_IDLE;
         w_cnt   = '0;
         w_sig   = 1'b0;
      end else if (r_state == ST_HIGH && r_cnt == w_act_high - W'(1)) begin
         w_state = ST_LOW;
         w_sig   = 1'b0;
      end
      if (w_bnd && w_nxt_period != '0) begin
         w_state = w_nxt_high != '0 ? ST_HIGH : ST_LOW;
         w_cnt   = '0;
         w_ps    = 1'b1;
         w_sig   = w_nxt_high != '0;
      end
   end
   assign sig          = r_sig;
   assign period_start = r_ps;
   assign busy         = r_state != ST_IDLE;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed and randomized checks of pwm_gen against a period-position model
module tb_pwm_gen;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [31:0] cfg_high = '0;
   logic [31:0] cfg_period = '0;
   logic        cfg_ready, sig, period_start, busy;
   int          total = 0;
   int          bad = 0;
   bit          chk_on = 1'b0;

   pwm_gen #(.W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_high     (cfg_high),
      .cfg_period   (cfg_period),
      .sig          (sig),
      .period_start (period_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: running flag plus position within the current period
   int unsigned m_high, m_per, m_ph, m_pp, m_pos;
   bit          m_run, m_pv, m_hs, m_last;
   always @(posedge clk) begin
      if (reset) begin
         m_high = 0; m_per = 0; m_ph = 0; m_pp = 0; m_pos = 0; m_run = 0; m_pv = 0;
      end else begin
         m_hs   = cfg_valid && !m_pv;
         m_last = m_run && (m_pos == m_per - 1);
         if (en && (m_last || (!m_run && (m_pv || m_per != 0)))) begin
            if (m_pv) begin
               m_high = m_ph; m_per = m_pp; m_pv = 0;
            end
            m_run = m_per != 0;
            m_pos = 0;
         end else if (m_last) begin
            m_run = 0;
            m_pos = 0;
         end else if (m_run) begin
            m_pos++;
         end
         if (m_hs) begin
            m_ph = cfg_high; m_pp = cfg_period; m_pv = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("cyc_sig",   sig,          32'(m_run && m_pos < m_high));
         chk("cyc_ps",    period_start, 32'(m_run && m_pos == 0));
         chk("cyc_busy",  busy,         32'(m_run));
         chk("cyc_ready", cfg_ready,    32'(!m_pv));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic cfg(input int unsigned h, input int unsigned p);
      int k = 0;
      while (!cfg_ready && k < 300) begin
         tick();
         k++;
      end
      chk("cfg_slot_free", cfg_ready, 1);
      cfg_high = h; cfg_period = p; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!cfg_ready && k < 300) begin
         tick();
         k++;
      end
      chk("transfer_timeout", cfg_ready, 1);
   endtask

   task automatic cap(input int n, output logic [31:0] s, output logic [31:0] p);
      s = '0; p = '0;
      for (int i = 0; i < n; i++) begin
         s = {s[30:0], sig};
         p = {p[30:0], period_start};
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] s, p;
      int hc, len;
      tick();
      chk_on = 1'b1;
      tick(); tick();
      chk("rst_sig", sig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_ps", period_start, 0);
      reset = 1'b0;
      tick();
      // basic 3/10
      cfg(3, 10);
      en = 1'b1;
      tick();
      chk("first_sig", sig, 1);
      chk("first_ps", period_start, 1);
      cap(20, s, p);
      chk("basic_sig", s, 32'b11100000001110000000);
      chk("basic_ps",  p, 32'b10000000001000000000);
      // mid-period update to 6/8
      repeat (3) tick();
      cfg(6, 8);
      chk("upd_ready_low", cfg_ready, 0);
      wait_ready();
      chk("upd_ps", period_start, 1);
      cap(8, s, p);
      chk("upd_sig", s, 32'b11111100);
      // handshake on the boundary is deferred one period
      repeat (7) tick();
      cfg_high = 2; cfg_period = 4; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("bnd_ps", period_start, 1);
      chk("bnd_ready", cfg_ready, 0);
      cap(8, s, p);
      chk("bnd_old_sig", s, 32'b11111100);
      chk("bnd_ready_after", cfg_ready, 1);
      cap(4, s, p);
      chk("bnd_new_sig", s, 32'b1100);
      // drop en at cnt=2 of a 3/10 period
      cfg(3, 10);
      wait_ready();
      repeat (2) tick();
      en = 1'b0;
      cap(8, s, p);
      chk("stop_tail", s, 32'b10000000);
      chk("stop_busy", busy, 0);
      chk("stop_sig", sig, 0);
      // 0% duty
      cfg(0, 5);
      en = 1'b1;
      tick();
      chk("zero_ps0", period_start, 1);
      cap(10, s, p);
      chk("zero_sig", s, 0);
      chk("zero_ps", p, 32'b1000010000);
      // high > period: 100% duty
      cfg(7, 5);
      wait_ready();
      chk("full_ps0", period_start, 1);
      cap(10, s, p);
      chk("full_sig", s, 32'b1111111111);
      chk("full_ps", p, 32'b1000010000);
      // period 1
      cfg(1, 1);
      wait_ready();
      cap(5, s, p);
      chk("p1_sig", s, 32'b11111);
      chk("p1_ps", p, 32'b11111);
      cfg(0, 1);
      wait_ready();
      cap(5, s, p);
      chk("p1z_sig", s, 0);
      chk("p1z_ps", p, 32'b11111);
      // period 0 stays idle
      en = 1'b0;
      tick(); tick();
      cfg(4, 0);
      en = 1'b1;
      repeat (3) tick();
      chk("p0_busy", busy, 0);
      chk("p0_sig", sig, 0);
      chk("p0_ready", cfg_ready, 1);
      // reset mid-HIGH
      cfg(3, 10);
      wait_ready();
      chk("rmid_ps", period_start, 1);
      tick();
      chk("rmid_high", sig, 1);
      reset = 1'b1;
      tick();
      chk("rmid_sig", sig, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_ready", cfg_ready, 1);
      reset = 1'b0;
      en = 1'b0;
      tick();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         cfg_valid  = $urandom_range(0, 7) == 0;
         cfg_high   = $urandom_range(0, 12);
         cfg_period = $urandom_range(0, 12);
         reset      = $urandom_range(0, 499) == 0;
         tick();
      end
      reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      // loopback measurement 25/100 over 16 periods
      cfg(25, 100);
      en = 1'b1;
      tick();
      chk("loop_ps0", period_start, 1);
      for (int n = 0; n < 16; n++) begin
         hc = 0; len = 0;
         do begin
            hc += int'(sig);
            len++;
            tick();
         end while (!period_start && len < 200);
         chk("loop_high", hc, 25);
         chk("loop_period", len, 100);
      end
      en = 1'b0;
      repeat (120) tick();
      chk("loop_idle", busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
